// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with start-glitch rejection and framing-error flag.
//
// The serial line is brought into the clock domain through a two-flop
// synchronizer. The start bit is confirmed at its midpoint. Every later bit
// is sampled one full bit period after the previous sample, so it is taken
// at mid-bit. Received bits are shifted in LSB first.
//
// Ports:
//   i_Clock         system clock, all logic on the rising edge
//   i_Reset         synchronous, active-high reset
//   i_Rx_Serial     asynchronous serial input, idle high
//   o_Rx_DV         one-cycle pulse, o_Rx_Byte holds a newly received byte
//   o_Rx_Byte       last good byte, held until the next good byte
//   o_Rx_Frame_Err  one-cycle pulse, stop bit sampled low
//   o_Rx_Active     high from start-bit confirmation until return to idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  // $clog2(N) bits always hold N-1, so the last count value never truncates.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    CLEANUP    = 3'd4,
    BREAK_WAIT = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       byte_reg, byte_next;
  logic             dv_reg, dv_next;
  logic             fe_reg, fe_next;
  logic             active_reg, active_next;
  logic             sync1_reg;
  logic             rx_s_reg;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      byte_reg   <= '0;
      dv_reg     <= 1'b0;
      fe_reg     <= 1'b0;
      active_reg <= 1'b0;
      // Synchronizer resets to the idle level so reset never fakes a start bit.
      sync1_reg  <= 1'b1;
      rx_s_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      byte_reg   <= byte_next;
      dv_reg     <= dv_next;
      fe_reg     <= fe_next;
      active_reg <= active_next;
      sync1_reg  <= i_Rx_Serial;
      rx_s_reg   <= sync1_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    byte_next   = byte_reg;
    dv_next     = 1'b0;
    fe_next     = 1'b0;
    active_next = active_reg;

    case (state_reg)
      IDLE: begin
        count_next = '0;
        idx_next   = '0;
        if (!rx_s_reg) state_next = START;
      end

      START: begin
        if (count_reg == HALF) begin
          count_next = '0;
          if (!rx_s_reg) begin
            active_next = 1'b1;
            state_next  = DATA;
          end else begin
            // Line went back high before mid start bit: treat as noise.
            state_next = IDLE;
          end
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end

      DATA: begin
        if (count_reg == LAST) begin
          count_next          = '0;
          shift_next[idx_reg] = rx_s_reg;
          if (idx_reg == 3'd7) begin
            idx_next   = '0;
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end

      STOP: begin
        if (count_reg == LAST) begin
          count_next = '0;
          if (rx_s_reg) begin
            byte_next  = shift_reg;
            dv_next    = 1'b1;
            state_next = CLEANUP;
          end else begin
            fe_next    = 1'b1;
            state_next = BREAK_WAIT;
          end
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end

      CLEANUP: begin
        active_next = 1'b0;
        state_next  = IDLE;
      end

      BREAK_WAIT: begin
        // A held-low line must not be seen as a stream of start bits.
        if (rx_s_reg) begin
          active_next = 1'b0;
          state_next  = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_Rx_DV        = dv_reg;
  assign o_Rx_Byte      = byte_reg;
  assign o_Rx_Frame_Err = fe_reg;
  assign o_Rx_Active    = active_reg;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_rx: a fast instance (16 clocks per bit) exercises
// the frame behaviour, a default-rate instance (5208) receives one byte.
module tb_uart_rx;

  logic clk    = 1'b0;
  logic srst   = 1'b1;
  logic rx16   = 1'b1;
  logic rx_big = 1'b1;

  logic       dv16, fe16, act16;
  logic [7:0] byte16;
  logic       dv_big, fe_big, act_big;
  logic [7:0] byte_big;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .i_Clock        (clk),
    .i_Reset        (srst),
    .i_Rx_Serial    (rx16),
    .o_Rx_DV        (dv16),
    .o_Rx_Byte      (byte16),
    .o_Rx_Frame_Err (fe16),
    .o_Rx_Active    (act16)
  );

  uart_rx dut_big (
    .i_Clock        (clk),
    .i_Reset        (srst),
    .i_Rx_Serial    (rx_big),
    .o_Rx_DV        (dv_big),
    .o_Rx_Byte      (byte_big),
    .o_Rx_Frame_Err (fe_big),
    .o_Rx_Active    (act_big)
  );

  // Posedge counter used to timestamp events.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge.
  logic [7:0] byte_q[$];
  int         dv_cyc_q[$];
  int         dv_total = 0;
  int         fe_total = 0;
  int         last_fe_cyc = 0;
  int         active_cycles = 0;
  int         viol = 0;
  logic       dv_prev = 1'b0;
  logic       fe_prev = 1'b0;
  int         big_dv_total = 0;
  logic [7:0] big_last = 8'h00;
  int         big_fe_total = 0;

  always @(negedge clk) begin
    if (dv16) begin
      byte_q.push_back(byte16);
      dv_cyc_q.push_back(cyc);
      dv_total = dv_total + 1;
    end
    if (fe16) begin
      fe_total = fe_total + 1;
      last_fe_cyc = cyc;
    end
    if (act16) active_cycles = active_cycles + 1;
    if ((dv16 && fe16) || (dv16 && dv_prev) || (fe16 && fe_prev)) viol = viol + 1;
    dv_prev = dv16;
    fe_prev = fe16;
    if (dv_big) begin
      big_dv_total = big_dv_total + 1;
      big_last = byte_big;
    end
    if (fe_big) big_fe_total = big_fe_total + 1;
  end

  int fall_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold one line level for n clocks; called on a falling edge.
  task automatic drive(input bit big, input logic v, input int n);
    if (big) rx_big = v;
    else     rx16 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit big, input logic [7:0] b, input logic stop_v);
    int cpb;
    cpb = big ? 5208 : 16;
    // The posedge following this falling edge is the first to see the start bit.
    if (!big) fall_cyc = cyc + 1;
    drive(big, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(big, b[i], cpb);
    drive(big, stop_v, cpb);
  endtask

  int dv0, fe0, act0, qb;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    chk("reset_dv", 32'(dv16), 32'h0);
    chk("reset_byte", 32'(byte16), 32'h00);
    chk("reset_fe", 32'(fe16), 32'h0);
    chk("reset_active", 32'(act16), 32'h0);
    repeat (5) @(negedge clk);

    // Frame 8'hA5 with exact timing
    dv0 = dv_total; fe0 = fe_total; act0 = active_cycles; qb = byte_q.size();
    send(0, 8'hA5, 1'b1);
    drive(0, 1'b1, 20);
    chk("a5_dv_count", 32'(dv_total - dv0), 32'd1);
    chk("a5_byte", 32'(byte_q[qb]), 32'hA5);
    chk("a5_latency", 32'(dv_cyc_q[qb] - fall_cyc), 32'd154);
    chk("a5_no_fe", 32'(fe_total - fe0), 32'd0);
    chk("a5_active_cycles", 32'(active_cycles - act0), 32'd145);
    chk("a5_active_idle", 32'(act16), 32'h0);

    // Frame 8'h00 with low stop bit, line held low 100 more cycles
    dv0 = dv_total; fe0 = fe_total;
    send(0, 8'h00, 1'b0);
    chk("fe_latency", 32'(last_fe_cyc - fall_cyc), 32'd154);
    drive(0, 1'b0, 100);
    chk("fe_active_in_break", 32'(act16), 32'h1);
    drive(0, 1'b1, 20);
    chk("fe_count", 32'(fe_total - fe0), 32'd1);
    chk("fe_no_dv", 32'(dv_total - dv0), 32'd0);
    chk("fe_byte_held", 32'(byte16), 32'hA5);
    chk("fe_active_idle", 32'(act16), 32'h0);
    qb = byte_q.size();
    send(0, 8'h81, 1'b1);
    drive(0, 1'b1, 20);
    chk("after_fe_byte", 32'(byte_q[qb]), 32'h81);

    // 4-cycle glitch then frame 8'h3C
    dv0 = dv_total; fe0 = fe_total; act0 = active_cycles;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    chk("glitch_no_dv", 32'(dv_total - dv0), 32'd0);
    chk("glitch_no_fe", 32'(fe_total - fe0), 32'd0);
    chk("glitch_no_active", 32'(active_cycles - act0), 32'd0);
    qb = byte_q.size();
    send(0, 8'h3C, 1'b1);
    drive(0, 1'b1, 20);
    chk("glitch_3c_count", 32'(dv_total - dv0), 32'd1);
    chk("glitch_3c_byte", 32'(byte_q[qb]), 32'h3C);
    chk("byte_stable", 32'(byte16), 32'h3C);

    // Back-to-back frames
    dv0 = dv_total; qb = byte_q.size();
    send(0, 8'h01, 1'b1);
    send(0, 8'hFF, 1'b1);
    send(0, 8'h7E, 1'b1);
    drive(0, 1'b1, 20);
    chk("b2b_count", 32'(dv_total - dv0), 32'd3);
    chk("b2b_byte0", 32'(byte_q[qb]), 32'h01);
    chk("b2b_byte1", 32'(byte_q[qb+1]), 32'hFF);
    chk("b2b_byte2", 32'(byte_q[qb+2]), 32'h7E);

    // Reset during data bit 4 of frame 8'hF0
    dv0 = dv_total; fe0 = fe_total;
    drive(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(0, 1'b0, 16);
    drive(0, 1'b1, 8);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("midreset_active", 32'(act16), 32'h0);
    chk("midreset_byte", 32'(byte16), 32'h00);
    chk("midreset_dv", 32'(dv16), 32'h0);
    chk("midreset_fe", 32'(fe16), 32'h0);
    drive(0, 1'b1, 200);
    chk("midreset_no_dv", 32'(dv_total - dv0), 32'd0);
    chk("midreset_no_fe", 32'(fe_total - fe0), 32'd0);
    qb = byte_q.size();
    send(0, 8'h55, 1'b1);
    drive(0, 1'b1, 20);
    chk("post_reset_55", 32'(byte_q[qb]), 32'h55);

    chk("pulse_rules", 32'(viol), 32'd0);

    // Default rate, one frame 8'hC3
    send(1, 8'hC3, 1'b1);
    drive(1, 1'b1, 20);
    chk("big_count", 32'(big_dv_total), 32'd1);
    chk("big_byte", 32'(big_last), 32'hC3);
    chk("big_no_fe", 32'(big_fe_total), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the team's uart_tx.
- Samples an asynchronous serial line with one system clock using a fixed clocks-per-bit count.
- Reassembles the data byte LSB first and presents it with a one-cycle valid strobe.
- Rejects start-bit glitches and flags framing errors. Sits between the board RX pin and the byte-level consumer logic.

Parameters:
CLKS_PER_BIT, 5208, system clocks per bit period (e.g. 50 MHz / 9600 baud); legal range 4..65535

Ports:
i_Clock  input  1  system clock, all logic on rising edge
i_Reset  input  1  synchronous, active-high reset
i_Rx_Serial  input  1  asynchronous serial line, idle high
o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a newly received valid byte
o_Rx_Byte  output  8  last good received byte; held until the next good byte
o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low
o_Rx_Active  output  1  high from start-bit confirmation until return to IDLE

Behaviour:
- Reset (i_Reset=1 at a clock edge):
  - state=IDLE; all counters=0.
  - o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Frame_Err=0, o_Rx_Active=0.
  - Both synchronizer flops=1.
  - Reset mid-frame aborts the frame with no DV and no error pulse. Reset has priority over everything.
- Input sync:
  - i_Rx_Serial passes through a 2-flop synchronizer; all decisions use the second flop (rx_s).
  - Pin-to-rx_s latency is 2 cycles.
- Clock counter width is $clog2(CLKS_PER_BIT); it must never truncate CLKS_PER_BIT-1. Bit index is 3 bits.
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- States:
  - IDLE: count=0, idx=0. If rx_s==0, go to START.
  - START: count increments each cycle. When count==HALF:
    - rx_s==0: count=0, o_Rx_Active=1, go to DATA.
    - rx_s==1: glitch; go to IDLE with no outputs.
  - DATA: count increments each cycle. When count==CLKS_PER_BIT-1:
    - shift register bit[idx] = rx_s; count=0.
    - idx<7: idx++. idx==7: idx=0, go to STOP.
    - Each data sample therefore lands at mid-bit.
  - STOP: when count==CLKS_PER_BIT-1, sample rx_s:
    - 1: o_Rx_Byte = shift register, o_Rx_DV=1 for exactly this one cycle, go to CLEANUP.
    - 0: o_Rx_Frame_Err=1 for one cycle, o_Rx_Byte unchanged, go to BREAK_WAIT.
  - CLEANUP: one cycle; o_Rx_DV back to 0; o_Rx_Active=0; go to IDLE.
  - BREAK_WAIT: stay while rx_s==0 (break/line held low, no new start detection). When rx_s==1: o_Rx_Active=0, go to IDLE.
  - Unused encodings go to IDLE.
- Boundary rules:
  - o_Rx_DV and o_Rx_Frame_Err are mutually exclusive and never high for more than one cycle.
  - A falling edge during CLEANUP is not missed: IDLE sees rx_s low on the next cycle. Back-to-back frames with a 1-bit stop are received without loss.
  - A line held low forever yields exactly one frame-error pulse (bytes all zero), then waits.
  - No FIFO: the consumer must capture o_Rx_Byte on o_Rx_DV. It stays stable until the next good byte.
- Latency: o_Rx_DV rises 2 + HALF + 9*CLKS_PER_BIT + 1 cycles after the pin's start-bit falling edge. This is 2 sync cycles plus the start-bit half-period, 8 data bits, the stop bit, and the registered output.

Test Plan:
- CLKS_PER_BIT=16, send 8'hA5 8N1 with exact bit timing -> one o_Rx_DV pulse, o_Rx_Byte=8'hA5, o_Rx_Frame_Err never high; DV at cycle 2+7+144+1=154 after the falling edge.
- Low pulse of 4 cycles on an idle line -> returns to IDLE, no DV, no error, o_Rx_Active stays 0; a following frame 8'h3C is received correctly.
- Frame 8'h00 with stop bit driven low, line then held low for 100 cycles -> one o_Rx_Frame_Err pulse, o_Rx_Byte keeps its previous value (8'hA5), no further pulses until the line returns high; next frame 8'h81 is received.
- Back-to-back frames 8'h01, 8'hFF, 8'h7E with no idle gap -> three DV pulses carrying 8'h01, 8'hFF, 8'h7E in order.
- Assert i_Reset for 1 cycle during data bit 4 of a frame -> no DV, all outputs 0 next cycle; a clean frame 8'h55 afterwards is received.
- CLKS_PER_BIT=5208 (default), one frame 8'hC3 -> received correctly, proving counter width covers 5207.
